fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/pc_register.sv | 32 +++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 fetch definitions: word width, NOP encoding, reset PC and fetch FSM states.
// FETCH_MISALIGN_CHECK_EN adds the TRAP state used by target-alignment checking.
package riscv_pkg;

  localparam int unsigned        XLEN             = 32;
  localparam logic [XLEN-1:0]    NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_TRAP  = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_e;
`endif

endpackage

// File: rtl/pc_register.sv
// Program counter: reset load, enabled update, next-PC select and +4 adder.
// Targets arrive as word addresses, so the two byte-offset bits always load as zero.
module pc_register
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_en,
  input  logic            i_sel_target,
  input  logic [XLEN-3:0] i_target_word,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;

  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc + XLEN'(4);
  assign w_pc_next  = i_sel_target ? {i_target_word, 2'b00} : o_pc_plus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_en) begin
      r_pc <= w_pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests the word at PC, registers it, and retires on !stall_in.
// Defining FETCH_MISALIGN_CHECK_EN adds the misalign output and a sticky TRAP state.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            stall_in,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            misalign,
`endif
  output logic            instr_valid
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_instr;
  logic            w_capture;
  logic            w_pc_en;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk           (clk),
    .reset         (reset),
    .i_en          (w_pc_en),
    .i_sel_target  (PCSrc),
    .i_target_word (PCTarget[XLEN-1:2]),
    .o_pc          (PC),
    .o_pc_plus4    (PCPlus4)
  );

`ifndef FETCH_MISALIGN_CHECK_EN
  logic w_unused_tgt_lsb;
  assign w_unused_tgt_lsb = ^PCTarget[1:0];
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_pc_en     = 1'b0;
    case (r_state)
      ST_FETCH, ST_WAIT: begin
        if (imem_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_VALID;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_VALID: begin
        if (!stall_in) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
            w_state_nxt = ST_TRAP;
          end else begin
            w_pc_en     = 1'b1;
            w_state_nxt = ST_FETCH;
          end
`else
          w_pc_en     = 1'b1;
          w_state_nxt = ST_FETCH;
`endif
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_TRAP: w_state_nxt = ST_TRAP;
`endif
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Reset wins over any ack in the same cycle, so an abandoned request is never captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_instr <= NOP_INSTR;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_instr <= imem_rdata;
      end
    end
  end

  assign imem_req    = !reset && ((r_state == ST_FETCH) || (r_state == ST_WAIT));
  assign imem_addr   = PC;
  assign instr       = r_instr;
  assign instr_valid = !reset && (r_state == ST_VALID);
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign    = (r_state == ST_TRAP);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with hand-computed expectations.
// Honors FETCH_MISALIGN_CHECK_EN to match the build of the design under test.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        stall_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .stall_in    (stall_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misalign    (misalign),
`endif
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1234_5000;
  endfunction

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; PCSrc = 1'b0; PCTarget = 32'h0; stall_in = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    #1;
    chk_vec("rst_req_in_cycle", imem_req, 1'b0);
    tick();
    chk_vec("rst_req", imem_req, 1'b0);
    chk_vec("rst_valid", instr_valid, 1'b0);
    chk_vec("rst_pc", PC, 32'h0);
    chk_vec("rst_instr", instr, 32'h0000_0013);

    reset = 1'b0; #1;
    chk_vec("first_req", imem_req, 1'b1);
    chk_vec("first_addr", imem_addr, 32'h0);

    // zero-wait memory: one instruction every two cycles
    for (int i = 0; i < 3; i++) begin
      chk_vec("seq_addr", imem_addr, 32'(4 * i));
      chk_vec("seq_req", imem_req, 1'b1);
      chk_vec("seq_nvalid", instr_valid, 1'b0);
      imem_ack = 1'b1; imem_rdata = mem_word(32'(4 * i));
      tick();
      imem_ack = 1'b0; imem_rdata = 32'hBAD0_0000;
      chk_vec("seq_valid", instr_valid, 1'b1);
      chk_vec("seq_instr", instr, mem_word(32'(4 * i)));
      chk_vec("seq_pc", PC, 32'(4 * i));
      chk_vec("seq_pcplus4", PCPlus4, 32'(4 * i + 4));
      chk_vec("seq_req_valid", imem_req, 1'b0);
      tick();
    end

    // delayed ack: request held four cycles
    for (int k = 0; k < 4; k++) begin
      chk_vec("wait_req", imem_req, 1'b1);
      chk_vec("wait_addr", imem_addr, 32'h0000_000C);
      chk_vec("wait_nvalid", instr_valid, 1'b0);
      chk_vec("wait_instr_hold", instr, mem_word(32'h8));
      if (k == 3) begin
        imem_ack = 1'b1; imem_rdata = mem_word(32'hC);
      end
      tick();
    end
    imem_ack = 1'b0;
    chk_vec("wait_valid", instr_valid, 1'b1);
    chk_vec("wait_instr", instr, mem_word(32'hC));

    // stall with PCSrc toggling and stray acks
    stall_in = 1'b1; PCTarget = 32'h0000_0080;
    for (int k = 0; k < 5; k++) begin
      PCSrc = k[0]; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      chk_vec("stall_pc", PC, 32'h0000_000C);
      chk_vec("stall_instr", instr, mem_word(32'hC));
      chk_vec("stall_valid", instr_valid, 1'b1);
      chk_vec("stall_req", imem_req, 1'b0);
    end
    imem_ack = 1'b0; stall_in = 1'b0; PCSrc = 1'b1; PCTarget = 32'h0000_0040;
    tick();
    chk_vec("branch_addr", imem_addr, 32'h0000_0040);
    chk_vec("branch_req", imem_req, 1'b1);
    chk_vec("branch_pcplus4", PCPlus4, 32'h0000_0044);

    // PCSrc/PCTarget ignored outside retire; then jump to the top word
    PCSrc = 1'b1; PCTarget = 32'h0000_0100;
    imem_ack = 1'b1; imem_rdata = mem_word(32'h40);
    tick();
    imem_ack = 1'b0;
    chk_vec("nonretire_pc", PC, 32'h0000_0040);
    chk_vec("b_instr", instr, mem_word(32'h40));
    PCTarget = 32'hFFFF_FFFC;
    tick();
    chk_vec("top_addr", imem_addr, 32'hFFFF_FFFC);
    PCSrc = 1'b0;
    imem_ack = 1'b1; imem_rdata = mem_word(32'hFFFF_FFFC);
    tick();
    imem_ack = 1'b0;
    chk_vec("top_pcplus4", PCPlus4, 32'h0000_0000);
    tick();
    chk_vec("wrap_addr", imem_addr, 32'h0000_0000);

    // move to PC 4, then reset mid-WAIT with a stray ack during reset
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
    tick();
    imem_ack = 1'b0;
    tick();
    chk_vec("pre_rst_addr", imem_addr, 32'h0000_0004);
    tick();
    chk_vec("pre_rst_wait_req", imem_req, 1'b1);
    reset = 1'b1; #1;
    chk_vec("rstwait_req", imem_req, 1'b0);
    chk_vec("rstwait_valid", instr_valid, 1'b0);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0; imem_ack = 1'b0; #1;
    chk_vec("rst2_pc", PC, 32'h0);
    chk_vec("rst2_instr", instr, 32'h0000_0013);
    chk_vec("rst2_req", imem_req, 1'b1);
    chk_vec("rst2_valid", instr_valid, 1'b0);
    tick();
    chk_vec("rst2_wait_req", imem_req, 1'b1);
    chk_vec("rst2_wait_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
    tick();
    imem_ack = 1'b0;
    chk_vec("rst2_instr_cap", instr, mem_word(32'h0));
    chk_vec("rst2_valid_cap", instr_valid, 1'b1);

    // misaligned branch target
    PCSrc = 1'b1; PCTarget = 32'h0000_0042;
    tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk_vec("mis_flag", misalign, 1'b1);
    chk_vec("mis_req", imem_req, 1'b0);
    chk_vec("mis_valid", instr_valid, 1'b0);
    chk_vec("mis_pc", PC, 32'h0);
    PCSrc = 1'b0; imem_ack = 1'b1;
    tick(); tick();
    chk_vec("mis_sticky", misalign, 1'b1);
    chk_vec("mis_sticky_req", imem_req, 1'b0);
    imem_ack = 1'b0;
`else
    chk_vec("mis_addr", imem_addr, 32'h0000_0040);
    chk_vec("mis_req", imem_req, 1'b1);
    chk_vec("mis_valid", instr_valid, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
